// File: rtl/btn_pulse_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : btn_pulse_gen_if
// Description : Signal bundle between the raw push-button pins and the button
//               conditioner. The master side owns the raw pins; the slave side
//               (btn_pulse_gen) returns debounced levels and one-cycle strobes.
// Ports       : btn_raw     - raw active-high pins, asynchronous to clk
//               btn_level   - debounced level per channel
//               btn_pulse   - one-cycle strobe on each accepted press
//               short_pulse - one-cycle strobe on release before long threshold
//               long_pulse  - one-cycle strobe when a hold reaches long threshold
// Revision    : 1.0 - initial release
// ============================================================================
interface btn_pulse_gen_if #(
    parameter int N_BTN = 6
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] short_pulse;
    logic [N_BTN-1:0] long_pulse;

    // Board / stimulus side: drives the pins, observes the conditioned results.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  short_pulse,
        input  long_pulse
    );

    // Conditioner side.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output short_pulse,
        output long_pulse
    );
endinterface : btn_pulse_gen_if
`default_nettype wire

// File: rtl/btn_pulse_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : btn_pulse_gen
// Description : Push-button front end. For each of N_BTN independent channels
//               the raw pin is synchronised (two flops), debounced by requiring
//               DEBOUNCE_CYCLES consecutive samples that differ from the
//               accepted level, and then classified into press, short-release
//               and long-press strobes, each exactly one clock wide.
//               Channel map: 0 power, 1 menu, 2 mode1, 3 mode2, 4 mode3,
//               5 self-clean.
// Ports       : clk    - system clock
//               rst    - asynchronous active-high reset, clears all state
//               bus_if - btn_pulse_gen_if.slave (raw pins in, level/strobes out)
// Revision    : 1.0 - initial release
// ============================================================================
module btn_pulse_gen #(
    parameter int N_BTN             = 6,
    parameter int DEBOUNCE_CYCLES   = 2_000_000,
    parameter int LONG_PRESS_CYCLES = 300_000_000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    btn_pulse_gen_if.slave     bus_if
);

    // ------------------------------------------------------------------------
    // Counter widths and comparison constants
    // ------------------------------------------------------------------------
    localparam int DCNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HCNT_W = $clog2(LONG_PRESS_CYCLES + 1);

    // Last count value before a differing sample is accepted.
    localparam logic [DCNT_W-1:0] C_DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    // Saturation value of the hold counter; reaching it qualifies a long press.
    localparam logic [HCNT_W-1:0] C_HCNT_MAX  = HCNT_W'(LONG_PRESS_CYCLES);
    localparam logic [HCNT_W-1:0] C_HCNT_PRE  = HCNT_W'(LONG_PRESS_CYCLES - 1);

    // Per-channel results gathered into vectors before reaching the interface.
    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_btn_pulse;
    logic [N_BTN-1:0] w_short_pulse;
    logic [N_BTN-1:0] w_long_pulse;

    // ------------------------------------------------------------------------
    // Per-channel conditioner
    //
    // The five channel states are carried implicitly:
    //   IDLE         stable = 0, dcnt = 0
    //   PRESS_PEND   stable = 0, sync2 = 1, dcnt counting
    //   HELD         stable = 1, hcnt < LONG
    //   LONG_HELD    stable = 1, hcnt = LONG
    //   RELEASE_PEND stable = 1, sync2 = 0, dcnt counting
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < N_BTN; g++) begin : g_chan
            // Synchroniser
            logic              sync1_q;
            logic              sync2_q;
            // Debounce
            logic              stable_q;
            logic              stable_d;
            logic              stable_dly_q;
            logic [DCNT_W-1:0] dcnt_q;
            logic [DCNT_W-1:0] dcnt_d;
            // Hold classification
            logic [HCNT_W-1:0] hcnt_q;
            logic [HCNT_W-1:0] hcnt_d;
            // Strobes
            logic              btn_pulse_q;
            logic              btn_pulse_d;
            logic              short_pulse_q;
            logic              short_pulse_d;
            logic              long_pulse_q;
            logic              long_pulse_d;

            // ---------------- next-state logic ----------------
            always_comb begin
                stable_d      = stable_q;
                dcnt_d        = '0;
                hcnt_d        = hcnt_q;
                btn_pulse_d   = 1'b0;
                short_pulse_d = 1'b0;
                long_pulse_d  = 1'b0;

                // Debounce: any sample agreeing with the accepted level
                // restarts the count, so only an unbroken run is accepted.
                if (sync2_q != stable_q) begin
                    if (dcnt_q == C_DCNT_LAST) begin
                        stable_d = sync2_q;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end

                // Hold counter saturates so a long hold can neither
                // re-trigger the long strobe nor wrap around.
                if (!stable_q) begin
                    hcnt_d = '0;
                end else if (hcnt_q != C_HCNT_MAX) begin
                    hcnt_d = hcnt_q + 1'b1;
                end

                // Rising edge of the debounced level.
                btn_pulse_d   = stable_q & ~stable_dly_q;

                // Falling edge; hcnt still holds the length of the finished
                // press on this cycle because it is only cleared next edge.
                short_pulse_d = ~stable_q & stable_dly_q & (hcnt_q < C_HCNT_MAX);

                // Exactly one strobe on the 9..→ LONG transition.
                long_pulse_d  = stable_q & (hcnt_q == C_HCNT_PRE);
            end

            // ---------------- state registers ----------------
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q       <= 1'b0;
                    sync2_q       <= 1'b0;
                    stable_q      <= 1'b0;
                    stable_dly_q  <= 1'b0;
                    dcnt_q        <= '0;
                    hcnt_q        <= '0;
                    btn_pulse_q   <= 1'b0;
                    short_pulse_q <= 1'b0;
                    long_pulse_q  <= 1'b0;
                end else begin
                    sync1_q       <= bus_if.btn_raw[g];
                    sync2_q       <= sync1_q;
                    stable_q      <= stable_d;
                    stable_dly_q  <= stable_q;
                    dcnt_q        <= dcnt_d;
                    hcnt_q        <= hcnt_d;
                    btn_pulse_q   <= btn_pulse_d;
                    short_pulse_q <= short_pulse_d;
                    long_pulse_q  <= long_pulse_d;
                end
            end

            assign w_level[g]       = stable_q;
            assign w_btn_pulse[g]   = btn_pulse_q;
            assign w_short_pulse[g] = short_pulse_q;
            assign w_long_pulse[g]  = long_pulse_q;
        end : g_chan
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus_if.btn_level   = w_level;
    assign bus_if.btn_pulse   = w_btn_pulse;
    assign bus_if.short_pulse = w_short_pulse;
    assign bus_if.long_pulse  = w_long_pulse;

endmodule : btn_pulse_gen
`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_btn_pulse_gen
// Description : Directed self-checking bench for btn_pulse_gen with
//               DEBOUNCE_CYCLES = 4 and LONG_PRESS_CYCLES = 10. Inputs are
//               driven and outputs sampled on the falling clock edge; "edge e"
//               is the e-th rising edge after a stimulus change (edge 0 is the
//               first one that samples it).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_pulse_gen;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    btn_pulse_gen_if #(.N_BTN(6)) bus_if ();

    btn_pulse_gen #(
        .N_BTN             (6),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] lv, input logic [5:0] bp,
                           input logic [5:0] sp, input logic [5:0] lp);
        chk({tag, " level"}, bus_if.btn_level,   lv);
        chk({tag, " press"}, bus_if.btn_pulse,   bp);
        chk({tag, " short"}, bus_if.short_pulse, sp);
        chk({tag, " long"},  bus_if.long_pulse,  lp);
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold channel c high for h cycles (edges 0..h-1 sample high), then
    // release and follow it back to idle. Expected timing:
    //   level high for 5 <= e < h+5, press strobe at e = 6,
    //   long strobe at e = 15 if h >= 10, else short strobe at e = h+6.
    task automatic press(input int c, input int h, input string tag);
        logic [5:0] m;
        logic [5:0] lv, bp, sp, lp;
        m = 6'd1 << c;
        bus_if.btn_raw = bus_if.btn_raw | m;
        for (int e = 0; e <= h + 8; e++) begin
            step();
            lv = (e >= 5 && e < h + 5) ? m : 6'd0;
            bp = (e == 6) ? m : 6'd0;
            lp = (h >= 10 && e == 15) ? m : 6'd0;
            sp = (h < 10 && e == h + 6) ? m : 6'd0;
            chk_all($sformatf("%s e%0d", tag, e), lv, bp, sp, lp);
            if (e == h - 1) bus_if.btn_raw = bus_if.btn_raw & ~m;
        end
    endtask

    initial begin
        // ---------------- reset with every pin high ----------------
        rst = 1'b1;
        bus_if.btn_raw = 6'h3F;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("reset c%0d", i), 6'h00, 6'h00, 6'h00, 6'h00);
        end
        rst = 1'b0;
        bus_if.btn_raw = 6'h00;
        step();
        chk_all("post_reset", 6'h00, 6'h00, 6'h00, 6'h00);
        step();

        // ---------------- clean press on menu ----------------
        press(1, 9, "clean");

        // ---------------- bounce on mode1: 1,1,1,0 x5 ----------------
        for (int e = 0; e < 26; e++) begin
            bus_if.btn_raw[2] = (e < 20) ? ((e % 4) != 3) : 1'b0;
            step();
            chk_all($sformatf("bounce e%0d", e), 6'h00, 6'h00, 6'h00, 6'h00);
        end

        // ---------------- long press on power ----------------
        press(0, 25, "long");

        // ---------------- short press on mode2 ----------------
        press(3, 8, "short");

        // ---------------- simultaneous presses + mid-hold reset ----------------
        bus_if.btn_raw = 6'b110000;
        for (int e = 0; e <= 8; e++) begin
            step();
            chk_all($sformatf("simul e%0d", e),
                    (e >= 5) ? 6'b110000 : 6'h00,
                    (e == 6) ? 6'b110000 : 6'h00, 6'h00, 6'h00);
        end
        rst = 1'b1;
        #1;
        chk_all("rst_async", 6'h00, 6'h00, 6'h00, 6'h00);
        step();
        chk_all("rst_hold0", 6'h00, 6'h00, 6'h00, 6'h00);
        step();
        chk_all("rst_hold1", 6'h00, 6'h00, 6'h00, 6'h00);
        rst = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            step();
            chk_all($sformatf("repress e%0d", e),
                    (e >= 5) ? 6'b110000 : 6'h00,
                    (e == 6) ? 6'b110000 : 6'h00, 6'h00, 6'h00);
        end
        bus_if.btn_raw = 6'h00;
        for (int i = 0; i < 12; i++) step();
        chk_all("final_idle", 6'h00, 6'h00, 6'h00, 6'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_btn_pulse_gen
`default_nettype wire
